// File: rtl/reg_port_sequencer_if.sv
// Bus bundle between reg_port_sequencer and its neighbours: request, operand,
// writeback and reg_file port signals. RP_IMM_MUX_EN adds the imm field.
interface reg_port_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              use_rs2;
`ifdef RP_IMM_MUX_EN
  logic [DATA_W-1:0] imm;
`endif
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] rf_address;
  logic              rf_write;
  logic [DATA_W-1:0] rf_in;
  logic [DATA_W-1:0] rf_out;
  logic              busy;

`ifdef RP_IMM_MUX_EN
  modport slave (
    input  instr_valid, rs1, rs2, use_rs2, imm, op_ready, wb_valid, wb_rd, wb_data, rf_out,
    output instr_ready, op_valid, op_a, op_b, wb_ready, rf_address, rf_write, rf_in, busy
  );
  modport master (
    output instr_valid, rs1, rs2, use_rs2, imm, op_ready, wb_valid, wb_rd, wb_data, rf_out,
    input  instr_ready, op_valid, op_a, op_b, wb_ready, rf_address, rf_write, rf_in, busy
  );
`else
  modport slave (
    input  instr_valid, rs1, rs2, use_rs2, op_ready, wb_valid, wb_rd, wb_data, rf_out,
    output instr_ready, op_valid, op_a, op_b, wb_ready, rf_address, rf_write, rf_in, busy
  );
  modport master (
    output instr_valid, rs1, rs2, use_rs2, op_ready, wb_valid, wb_rd, wb_data, rf_out,
    input  instr_ready, op_valid, op_a, op_b, wb_ready, rf_address, rf_write, rf_in, busy
  );
`endif
endinterface

// File: rtl/reg_port_sequencer.sv
// Operand-fetch / writeback sequencer in front of a single-port reg_file with
// registered read data. Optional RP_IMM_MUX_EN routes an immediate onto op_b.
module reg_port_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_port_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CAP_A, CAP_B, OUT, WB
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic              use_rs2_q, use_rs2_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [ADDR_W-1:0] rf_address_q, rf_address_d;
  logic [DATA_W-1:0] rf_in_q, rf_in_d;
  logic              rf_write_q, rf_write_d;
  logic              instr_ready, wb_ready;
`ifdef RP_IMM_MUX_EN
  logic [DATA_W-1:0] imm_q, imm_d;
`endif

  // rf_* are registered from the next state, so they are valid for the whole
  // RD_A/RD_B/WB cycle and hold their value everywhere else.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d      = state_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    use_rs2_d    = use_rs2_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rf_address_d = rf_address_q;
    rf_in_d      = rf_in_q;
    rf_write_d   = 1'b0;
    instr_ready  = 1'b0;
    wb_ready     = 1'b0;
`ifdef RP_IMM_MUX_EN
    imm_d        = imm_q;
`endif

    case (state_q)
      IDLE: begin
        wb_ready    = 1'b1;
        instr_ready = !bus.wb_valid;
        if (bus.wb_valid) begin
          // Writes to x0 are accepted and silently dropped.
          if (bus.wb_rd != '0) begin
            rf_address_d = bus.wb_rd;
            rf_in_d      = bus.wb_data;
            rf_write_d   = 1'b1;
            state_d      = WB;
          end
        end else if (bus.instr_valid) begin
          rs1_d        = bus.rs1;
          rs2_d        = bus.rs2;
          use_rs2_d    = bus.use_rs2;
`ifdef RP_IMM_MUX_EN
          imm_d        = bus.imm;
`endif
          rf_address_d = bus.rs1;
          state_d      = RD_A;
        end
      end
      RD_A: begin
        if (use_rs2_q) begin
          rf_address_d = rs2_q;
          state_d      = RD_B;
        end else begin
          state_d      = CAP_A;
        end
      end
      RD_B: begin
        op_a_d  = (rs1_q == '0) ? '0 : bus.rf_out;
        state_d = CAP_B;
      end
      CAP_A: begin
        op_a_d  = (rs1_q == '0) ? '0 : bus.rf_out;
`ifdef RP_IMM_MUX_EN
        op_b_d  = imm_q;
`else
        op_b_d  = '0;
`endif
        state_d = OUT;
      end
      CAP_B: begin
        op_b_d  = (rs2_q == '0) ? '0 : bus.rf_out;
        state_d = OUT;
      end
      OUT: begin
        if (bus.op_ready) state_d = IDLE;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      use_rs2_q    <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rf_address_q <= '0;
      rf_in_q      <= '0;
      rf_write_q   <= 1'b0;
`ifdef RP_IMM_MUX_EN
      imm_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      use_rs2_q    <= use_rs2_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rf_address_q <= rf_address_d;
      rf_in_q      <= rf_in_d;
      rf_write_q   <= rf_write_d;
`ifdef RP_IMM_MUX_EN
      imm_q        <= imm_d;
`endif
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.wb_ready    = wb_ready;
  assign bus.op_valid    = (state_q == OUT);
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.rf_address  = rf_address_q;
  assign bus.rf_in       = rf_in_q;
  assign bus.rf_write    = rf_write_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Self-checking bench for reg_port_sequencer: behavioural reg_file plus an
// architectural register image used to predict operands. Honours RP_IMM_MUX_EN.
module tb_reg_port_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_port_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_port_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural reg_file: one port, registered read data, no x0 special case.
  logic [DW-1:0] regs [32];
  always @(posedge clk) begin
    if (bus.rf_write) regs[bus.rf_address] <= bus.rf_in;
    else              bus.rf_out <= regs[bus.rf_address];
  end

  // Architectural view the sequencer should present (x0 always reads 0).
  logic [DW-1:0] gold [32];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic issue_read(input string tag, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                            input logic use2, input logic [DW-1:0] immv, input int stall,
                            input bit poke);
    logic [DW-1:0] exp_a, exp_b;
    int guard, lat, exp_lat;
    exp_a   = (r1 == 0) ? '0 : gold[r1];
    exp_b   = '0;
    if (use2) exp_b = (r2 == 0) ? '0 : gold[r2];
`ifdef RP_IMM_MUX_EN
    else      exp_b = immv;
`endif
    exp_lat = use2 ? 3 : 2;

    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.rs1 = r1; bus.rs2 = r2; bus.use_rs2 = use2;
`ifdef RP_IMM_MUX_EN
    bus.imm = immv;
`endif
    #1;
    guard = 0;
    while (!bus.instr_ready && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    n_checks++;
    if (bus.instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s accept: instr_ready=%b required 1", tag, bus.instr_ready);
      bus.instr_valid = 1'b0; return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;

    lat = 0;
    while (!bus.op_valid && lat < 10) begin
      n_checks++;
      if (bus.rf_write !== 1'b0) begin
        n_fail++; $display("FAIL %s rf_write_during_read: got %b required 0", tag, bus.rf_write);
      end
      if (lat == 0) begin
        n_checks++;
        if (bus.rf_address !== r1) begin
          n_fail++; $display("FAIL %s addr_a: got %0d required %0d", tag, bus.rf_address, r1);
        end
      end else if (lat == 1) begin
        n_checks++;
        if (bus.rf_address !== (use2 ? r2 : r1)) begin
          n_fail++; $display("FAIL %s addr_b: got %0d required %0d", tag, bus.rf_address, use2 ? r2 : r1);
        end
      end
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d required %0d", tag, lat, exp_lat);
    end

    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'hA5A5_A5A5;
        bus.instr_valid = 1'b1;
        #1;
      end
      n_checks++;
      if ({bus.op_valid, bus.op_a, bus.op_b, bus.instr_ready, bus.wb_ready}
          !== {1'b1, exp_a, exp_b, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL %s stall_%0d: valid=%b a=%h b=%h ir=%b wr=%b required 1 %h %h 0 0",
                 tag, i, bus.op_valid, bus.op_a, bus.op_b, bus.instr_ready, bus.wb_ready, exp_a, exp_b);
      end
      @(negedge clk);
    end
    bus.wb_valid = 1'b0; bus.instr_valid = 1'b0;

    n_checks++;
    if ({bus.op_valid, bus.op_a, bus.op_b} !== {1'b1, exp_a, exp_b}) begin
      n_fail++;
      $display("FAIL %s operands: valid=%b a=%h b=%h required 1 %h %h",
               tag, bus.op_valid, bus.op_a, bus.op_b, exp_a, exp_b);
    end
    bus.op_ready = 1'b1;
    @(negedge clk);
    bus.op_ready = 1'b0;
    n_checks++;
    if ({bus.busy, bus.op_valid} !== 2'b00) begin
      n_fail++; $display("FAIL %s release: busy=%b op_valid=%b required 0 0", tag, bus.busy, bus.op_valid);
    end
  endtask

  task automatic issue_wb(input string tag, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.wb_rd = rd; bus.wb_data = data;
    #1;
    n_checks++;
    if ({bus.wb_ready, bus.instr_ready} !== 2'b10) begin
      n_fail++; $display("FAIL %s wb_ready: wr=%b ir=%b required 1 0", tag, bus.wb_ready, bus.instr_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.wb_valid = 1'b0;
    n_checks++;
    if (rd != 0) begin
      if ({bus.rf_write, bus.rf_address, bus.rf_in} !== {1'b1, rd, data}) begin
        n_fail++;
        $display("FAIL %s wb_pulse: we=%b addr=%0d in=%h required 1 %0d %h",
                 tag, bus.rf_write, bus.rf_address, bus.rf_in, rd, data);
      end
      gold[rd] = data;
    end else if ({bus.rf_write, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL %s wb_x0: we=%b busy=%b required 0 0", tag, bus.rf_write, bus.busy);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.rf_write, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL %s wb_end: we=%b busy=%b required 0 0", tag, bus.rf_write, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({bus.op_valid, bus.busy, bus.rf_write, bus.rf_address, bus.rf_in, bus.op_a, bus.op_b}
        !== {1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: v=%b busy=%b we=%b addr=%0d in=%h a=%h b=%h required all 0",
               bus.op_valid, bus.busy, bus.rf_write, bus.rf_address, bus.rf_in, bus.op_a, bus.op_b);
    end
    n_checks++;
    if ({bus.instr_ready, bus.wb_ready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_ready: ir=%b wr=%b required 1 1", bus.instr_ready, bus.wb_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_rtype();
    issue_read("rtype", 5'd5, 5'd6, 1'b1, 32'h0, 0, 1'b0);
  endtask

  task automatic test_read_itype();
    issue_read("itype", 5'd5, 5'd0, 1'b0, 32'hFFFF_FFF0, 0, 1'b0);
  endtask

  task automatic test_wb_priority();
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
    bus.instr_valid = 1'b1; bus.rs1 = 5'd5; bus.rs2 = 5'd0; bus.use_rs2 = 1'b0;
    #1;
    n_checks++;
    if ({bus.wb_ready, bus.instr_ready} !== 2'b10) begin
      n_fail++; $display("FAIL prio_ready: wr=%b ir=%b required 1 0", bus.wb_ready, bus.instr_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.wb_valid = 1'b0;
    n_checks++;
    if ({bus.rf_write, bus.rf_address, bus.rf_in, bus.instr_ready}
        !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_wb: we=%b addr=%0d in=%h ir=%b required 1 5 deadbeef 0",
               bus.rf_write, bus.rf_address, bus.rf_in, bus.instr_ready);
    end
    gold[5] = 32'hDEAD_BEEF;
    issue_read("prio_read", 5'd5, 5'd0, 1'b0, 32'h1357_9BDF, 0, 1'b0);
  endtask

  task automatic test_wb_x0();
    regs[0] = 32'hBAD0_0BAD;
    issue_wb("wb_x0", 5'd0, 32'h0000_1234);
    issue_read("x0_read", 5'd0, 5'd0, 1'b1, 32'h0, 0, 1'b0);
  endtask

  task automatic test_stall();
    issue_read("stall", 5'd6, 5'd5, 1'b1, 32'h0, 5, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.rs1 = 5'd5; bus.rs2 = 5'd6; bus.use_rs2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.op_valid, bus.rf_write, bus.busy, bus.op_a, bus.op_b}
        !== {1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b we=%b busy=%b a=%h b=%h required 0 0 0 0 0",
               bus.op_valid, bus.rf_write, bus.busy, bus.op_a, bus.op_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue_read("after_reset", 5'd6, 5'd6, 1'b1, 32'h0, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        issue_wb("rand_wb", AW'($urandom_range(0, 7)), $urandom);
      else
        issue_read("rand_rd", AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.use_rs2 = 1'b0;
    bus.op_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.rf_out = '0;
`ifdef RP_IMM_MUX_EN
    bus.imm = '0;
`endif
    for (int i = 0; i < 32; i++) begin
      regs[i] = $urandom;
      gold[i] = regs[i];
    end
    regs[0] = 32'h0BAD_F00D; gold[0] = '0;
    regs[5] = 32'h0000_0011; gold[5] = 32'h0000_0011;
    regs[6] = 32'h0000_0022; gold[6] = 32'h0000_0022;

    test_reset();
    test_read_rtype();
    test_read_itype();
    test_wb_priority();
    test_wb_x0();
    test_stall();
    test_reset_mid_op();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_port_sequencer.md
Name: reg_port_sequencer

Overview:
- Operand-fetch and writeback sequencer placed directly upstream of reg_file, which has a single address port, a single write strobe and a registered read output.
- Accepts a decoded register request (rs1, optional rs2) and issues reg_file reads one per cycle. Captures the registered read data and presents the operand pair with a valid/ready handshake.
- Arbitrates ALU writeback requests onto the same port.
- Enforces x0 semantics: x0 reads return 0; x0 writes are dropped.

Parameters:
- DATA_W, 32, operand/register data width.
- ADDR_W, 5, register index width (32 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- instr_valid  in  1  request valid.
- instr_ready  out  1  request accepted when valid&ready at rising edge.
- rs1  in  ADDR_W  source register A index.
- rs2  in  ADDR_W  source register B index.
- use_rs2  in  1  1: fetch rs2 (r_type); 0: A only (i_type).
- op_valid  out  1  operands valid.
- op_ready  in  1  consumer accepts operands.
- op_a  out  DATA_W  value of rs1.
- op_b  out  DATA_W  value of rs2, or 0 (see Optional Feature).
- wb_valid  in  1  writeback request.
- wb_ready  out  1  writeback accepted when valid&ready.
- wb_rd  in  ADDR_W  destination index.
- wb_data  in  DATA_W  writeback data.
- rf_address  out  ADDR_W  to reg_file address.
- rf_write  out  1  to reg_file write (1 = write, 0 = read).
- rf_in  out  DATA_W  to reg_file in.
- rf_out  in  DATA_W  from reg_file out. This is registered: it reflects registers[address] sampled at the previous edge with write=0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, rst_n=0):
  - state=IDLE.
  - op_a=op_b=0, op_valid=0.
  - rf_write=0, rf_address=0, rf_in=0.
  - Latched rs2/use_rs2/wb fields cleared.
  - Takes effect mid-operation without any cleanup write.
  - Deassertion is used synchronously by the FSM from the next edge.
- FSM states are IDLE, RD_A, RD_B, CAP_A, CAP_B, OUT and WB. rf_* outputs are Moore-decoded from state and latched fields.
- IDLE:
  - wb_ready=1.
  - instr_ready = !wb_valid. Writeback has priority, so a same-cycle request sees the new value.
  - wb_valid & wb_rd!=0: latch wb_rd/wb_data and go to WB.
  - wb_valid & wb_rd==0: accept and stay IDLE, with no rf_write pulse.
  - Otherwise, instr_valid: latch rs1/rs2/use_rs2 and go to RD_A.
- RD_A: rf_address=rs1, rf_write=0. Next state is RD_B if use_rs2, else CAP_A.
- RD_B: rf_address=rs2. At the edge, op_a <= (rs1==0) ? 0 : rf_out. Next state CAP_B.
- CAP_A: at the edge, op_a <= (rs1==0) ? 0 : rf_out, and op_b <= 0. Next state OUT.
- CAP_B: at the edge, op_b <= (rs2==0) ? 0 : rf_out. Next state OUT.
- OUT:
  - op_valid=1; op_a/op_b are held stable.
  - op_ready: go to IDLE.
  - rf_write=0, rf_address holds its last value.
  - wb_ready=0 and instr_ready=0.
- WB: rf_address=wb_rd, rf_in=wb_data, rf_write=1 for exactly one cycle, then IDLE.
- Latency, counted from the accept edge to op_valid high:
  - 3 cycles with use_rs2=1.
  - 2 cycles with use_rs2=0.
  - A writeback occupies 1 cycle; the next request can be accepted in the cycle after WB.
- Throughput: one request in flight. No pipelining; a zero-bubble op_ready does not skip IDLE.
- Outside RD_A/RD_B/WB: rf_write=0. rf_address is unchanged except when a read or write state drives it.
- rs1==rs2: read twice. rs==0: the result is forced to 0 regardless of reg_file contents.

Optional Feature:
- Macro RP_IMM_MUX_EN.
- Defined:
  - Adds input port imm, DATA_W wide.
  - Latched at instr accept.
  - In CAP_A, op_b <= imm_latched, giving an i_type immediate on operand B.
- Undefined:
  - No imm port.
  - op_b = 0 when use_rs2=0.

Test Plan:
- Model preload x5=0x0000_0011, x6=0x0000_0022. Request rs1=5, rs2=6, use_rs2=1 -> op_valid 3 cycles after accept; op_a=0x11, op_b=0x22; rf_address sequence 5,6; rf_write stays 0.
- Request rs1=5, use_rs2=0 -> op_valid after 2 cycles; op_a=0x11. op_b=0 (macro off), or op_b=imm=0xFFFF_FFF0 (macro on).
- wb_valid and instr_valid asserted in the same IDLE cycle, wb_rd=5, wb_data=0xDEAD_BEEF, rs1=5 -> wb accepted first, single rf_write pulse with address 5, then the read returns op_a=0xDEAD_BEEF.
- wb_rd=0, wb_data=0x1234 -> wb_ready=1, no rf_write pulse. A subsequent read with rs1=0, rs2=0 gives op_a=op_b=0 even if the model holds a nonzero x0.
- Hold op_ready=0 for 5 cycles in OUT -> op_valid, op_a and op_b stable; instr_ready=0 and wb_ready=0 throughout. Then op_ready=1 -> IDLE next cycle.
- Assert rst_n=0 mid-RD_B, asynchronously between edges -> immediately op_valid=0, rf_write=0, busy=0, op_a=op_b=0. After release, a new request completes normally.
